// File: rtl/fc_argmax_classifier.sv
// rtl/fc_argmax_classifier.sv - serial argmax over class scores with top-1/top-2 margin
module fc_argmax_classifier #(
    parameter int DATA_W      = 16,
    parameter int NUM_CLASSES = 10,
    parameter int IDX_W       = 4
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  class_idx,
    output logic [DATA_W-1:0] max_score,
    output logic [DATA_W-1:0] margin,
    output logic              frame_err,
    output logic              busy
);

    typedef enum logic {ACCUM, DONE} state_t;

    localparam logic signed [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0]        SAT_MAX  = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [IDX_W-1:0]         LAST_CNT = IDX_W'(NUM_CLASSES - 1);

    state_t                    state;
    logic [IDX_W-1:0]          cnt;
    logic [IDX_W-1:0]          best_idx;
    logic signed [DATA_W-1:0]  best;
    logic signed [DATA_W-1:0]  second;

    logic                      accept;
    logic                      at_last_cnt;
    logic                      frame_end;
    logic signed [DATA_W-1:0]  din;
    logic signed [DATA_W-1:0]  nxt_best;
    logic signed [DATA_W-1:0]  nxt_second;
    logic [IDX_W-1:0]          nxt_idx;
    logic signed [DATA_W:0]    diff;
    logic [DATA_W-1:0]         nxt_margin;

    assign in_ready    = (state == ACCUM) && !RST;
    assign accept      = in_valid && in_ready;
    assign din         = $signed(in_data);
    assign at_last_cnt = (cnt == LAST_CNT);
    assign frame_end   = in_last || at_last_cnt;
    assign busy        = !RST && ((state == DONE) || (cnt != '0));

    // Running top-2 including the current beat, so the frame-end beat lands in the result.
    always_comb begin
        nxt_best   = best;
        nxt_second = second;
        nxt_idx    = best_idx;
        if (cnt == '0) begin
            nxt_best   = din;
            nxt_second = MOST_NEG;
            nxt_idx    = '0;
        end else if (din > best) begin
            nxt_second = best;
            nxt_best   = din;
            nxt_idx    = cnt;
        end else if (din > second) begin
            nxt_second = din;
        end
        // best >= second always, so diff is non-negative; saturate anything above SAT_MAX.
        diff       = {nxt_best[DATA_W-1], nxt_best} - {nxt_second[DATA_W-1], nxt_second};
        nxt_margin = (diff[DATA_W] || diff[DATA_W-1]) ? SAT_MAX : diff[DATA_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state     <= ACCUM;
            cnt       <= '0;
            best      <= '0;
            second    <= '0;
            best_idx  <= '0;
            out_valid <= 1'b0;
            class_idx <= '0;
            max_score <= '0;
            margin    <= '0;
            frame_err <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        best     <= nxt_best;
                        second   <= nxt_second;
                        best_idx <= nxt_idx;
                        if (frame_end) begin
                            cnt       <= '0;
                            state     <= DONE;
                            out_valid <= 1'b1;
                            class_idx <= nxt_idx;
                            max_score <= nxt_best;
                            margin    <= nxt_margin;
                            frame_err <= (in_last != at_last_cnt);
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_fc_argmax_classifier.sv
// tb/tb_fc_argmax_classifier.sv - scoreboard bench for fc_argmax_classifier
module tb_fc_argmax_classifier;

    localparam int N  = 10;
    localparam int DW = 16;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          RST;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] class_idx;
    logic [DW-1:0] max_score;
    logic [DW-1:0] margin;
    logic          frame_err;
    logic          busy;

    always #5 clk = ~clk;

    fc_argmax_classifier #(.DATA_W(DW), .NUM_CLASSES(N), .IDX_W(IW)) dut (
        .clk(clk), .RST(RST),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .class_idx(class_idx), .max_score(max_score), .margin(margin),
        .frame_err(frame_err), .busy(busy)
    );

    typedef struct {
        int idx;
        int score;
        int margin;
        bit err;
    } exp_t;

    exp_t sb[$];
    int   mbuf[$];
    bit   use_model;
    int   ready_mode;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: argmax with first-occurrence tie-break, runner-up taken over the
    // remaining entries, margin clipped to the positive range of the score type.
    function automatic exp_t model(input int q[$], input bit last);
        exp_t r;
        int   mx, sec, m;
        mx = q[0];
        r.idx = 0;
        foreach (q[i]) if (q[i] > mx) begin mx = q[i]; r.idx = i; end
        sec = -32768;
        foreach (q[i]) if (i != r.idx && q[i] > sec) sec = q[i];
        m = mx - sec;
        r.score  = mx;
        r.margin = (m > 32767) ? 32767 : m;
        r.err    = !(last && q.size() == N);
        return r;
    endfunction

    task automatic expect_res(input int i, input int s, input int m, input bit e);
        exp_t r;
        r.idx = i; r.score = s; r.margin = m; r.err = e;
        sb.push_back(r);
    endtask

    task automatic model_beat(input int d, input bit last);
        if (use_model) begin
            mbuf.push_back(d);
            if (last || mbuf.size() == N) begin
                sb.push_back(model(mbuf, last));
                mbuf.delete();
            end
        end
    endtask

    task automatic send_beat(input int d, input bit last);
        int t;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d[DW-1:0];
        in_last  = last;
        t = 0;
        while (!in_ready && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 1000) begin
            checks++; errors++;
            $display("FAIL beat_timeout: in_ready stuck low for %0d cycles, required 1", t);
        end
        model_beat(d, last);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_list(input int s[$], input bit with_last);
        foreach (s[i]) send_beat(s[i], with_last && (i == s.size() - 1));
    endtask

    // Monitor: drives out_ready, pops the scoreboard on each handshake and
    // checks the result is held while stalled.
    initial begin : monitor
        bit            hold_prev;
        logic [IW-1:0] h_idx;
        logic [DW-1:0] h_score, h_margin;
        logic          h_err;
        exp_t          e;
        hold_prev = 1'b0;
        h_idx = '0; h_score = '0; h_margin = '0; h_err = 1'b0;
        forever begin
            @(negedge clk);
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
            if (hold_prev && out_valid) begin
                check("hold_class_idx", int'(class_idx), int'(h_idx));
                check("hold_max_score", int'(max_score), int'(h_score));
                check("hold_margin", int'(margin), int'(h_margin));
                check("hold_frame_err", int'(frame_err), int'(h_err));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_result: got class_idx %0d, required no result", class_idx);
                end else begin
                    e = sb.pop_front();
                    check("class_idx", int'(class_idx), e.idx);
                    check("max_score", int'($signed(max_score)), e.score);
                    check("margin", int'(margin), e.margin);
                    check("frame_err", int'(frame_err), int'(e.err));
                end
            end
            hold_prev = out_valid && !out_ready;
            h_idx = class_idx; h_score = max_score; h_margin = margin; h_err = frame_err;
        end
    end

    initial begin : stimulus
        int               q[$];
        int               t;
        int               len, d, r;
        bit               last;
        logic signed [15:0] s16;

        RST = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
        out_ready = 1'b1; ready_mode = 0; use_model = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_class_idx", int'(class_idx), 0);
        check("rst_max_score", int'(max_score), 0);
        check("rst_margin", int'(margin), 0);
        check("rst_frame_err", int'(frame_err), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_in_ready", int'(in_ready), 0);
        RST = 1'b0;

        // Basic frame plus in_ready timing around the result handshake.
        q = '{5, -3, 100, 7, 0, 2, 99, -128, 1, 4};
        expect_res(2, 100, 1, 1'b0);
        send_list(q, 1'b1);
        idle();
        check("basic_out_valid", int'(out_valid), 1);
        check("basic_in_ready_done", int'(in_ready), 0);
        check("basic_busy_done", int'(busy), 1);
        @(negedge clk);
        check("basic_in_ready_back", int'(in_ready), 1);
        check("basic_out_valid_clr", int'(out_valid), 0);

        // Ties and negatives.
        q = '{-50, -50, -50, -50, -50, -50, -50, -50, -50, -50};
        expect_res(0, -50, 0, 1'b0);
        send_list(q, 1'b1);
        q = '{3, 9, 9, 0, 0, 0, 0, 0, 0, 0};
        expect_res(1, 9, 0, 1'b0);
        send_list(q, 1'b1);
        idle();

        // Saturated margin with the result held under back-pressure.
        ready_mode = 2;
        q = '{32767, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768};
        expect_res(0, 32767, 32767, 1'b0);
        send_list(q, 1'b1);
        idle();
        t = 0;
        while (!out_valid && t < 50) begin @(negedge clk); t++; end
        check("bp_result_seen", int'(out_valid), 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = 16'h1234; in_last = 1'b1;
            #1;
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_out_valid", int'(out_valid), 1);
        end
        in_valid = 1'b0; in_last = 1'b0;
        ready_mode = 0;
        idle();

        // Framing errors: early last, missing last, then a clean frame.
        q = '{1, 2, 8, 4};
        expect_res(2, 8, 4, 1'b1);
        send_list(q, 1'b1);
        q = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
        expect_res(9, 9, 1, 1'b1);
        send_list(q, 1'b0);
        q = '{5, -3, 100, 7, 0, 2, 99, -128, 1, 4};
        expect_res(2, 100, 1, 1'b0);
        send_list(q, 1'b1);
        idle();
        repeat (3) @(negedge clk);

        // Reset in the middle of a frame.
        q = '{10, 20, 30, 40, 50, 60};
        send_list(q, 1'b0);
        @(negedge clk);
        in_valid = 1'b1; in_data = 16'h7000; in_last = 1'b1; RST = 1'b1;
        #1;
        check("mid_rst_in_ready", int'(in_ready), 0);
        check("mid_rst_busy", int'(busy), 0);
        @(negedge clk);
        check("mid_rst_out_valid", int'(out_valid), 0);
        check("mid_rst_class_idx", int'(class_idx), 0);
        check("mid_rst_max_score", int'(max_score), 0);
        check("mid_rst_margin", int'(margin), 0);
        check("mid_rst_frame_err", int'(frame_err), 0);
        check("mid_rst_busy2", int'(busy), 0);
        RST = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        @(negedge clk);
        check("post_rst_busy", int'(busy), 0);
        check("post_rst_in_ready", int'(in_ready), 1);
        q = '{-40, -30, -20, -10, 0, 10, 20, 30, 40, 50};
        expect_res(9, 50, 10, 1'b0);
        send_list(q, 1'b1);
        idle();

        // Randomized frames with throttled input and output.
        use_model  = 1'b1;
        ready_mode = 1;
        for (int f = 0; f < 100; f++) begin
            r = $urandom_range(0, 9);
            if (r < 7)      begin len = N; last = 1'b1; end
            else if (r < 9) begin len = $urandom_range(1, N - 1); last = 1'b1; end
            else            begin len = $urandom_range(1, N); last = 1'b0; end
            for (int b = 0; b < len; b++) begin
                if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 2)) idle();
                if ($urandom_range(0, 1) == 1) d = $urandom_range(0, 6) - 3;
                else begin s16 = 16'($urandom); d = s16; end
                send_beat(d, last && (b == len - 1));
            end
        end
        if (mbuf.size() != 0) send_beat(0, 1'b1);
        idle();

        t = 0;
        while (sb.size() != 0 && t < 2000) begin @(negedge clk); t++; end
        if (sb.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain: %0d results outstanding, required 0", sb.size());
        end
        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fc_argmax_classifier.md
Name: fc_argmax_classifier

Overview:
- Sequential output stage that sits directly downstream of the second dense layer.
- It consumes the layer's class scores as a serial valid/ready stream, one signed score per beat.
- Per frame it reports the winning class index, the winning score, and a confidence margin (top-1 minus top-2).
- It replaces the unclocked max-scan after the dense layer with a registered, back-pressured result.

Parameters:
- DATA_W, 16, score width; signed two's complement fixed point.
- NUM_CLASSES, 10, scores per frame; must be ≥ 2.
- IDX_W, 4, class index width; must satisfy 2^IDX_W ≥ NUM_CLASSES.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- RST  input  1  synchronous, active-high reset.
- in_valid  input  1  score beat valid.
- in_ready  output  1  stage can accept a beat.
- in_data  input  DATA_W  signed class score; beat k of a frame is class k.
- in_last  input  1  marks final beat of a frame.
- out_valid  output  1  result valid; held until accepted.
- out_ready  input  1  consumer accepts the result.
- class_idx  output  IDX_W  index of the maximum score.
- max_score  output  DATA_W  maximum score.
- margin  output  DATA_W  max_score minus second-highest score, saturated; unsigned value.
- frame_err  output  1  frame length did not match NUM_CLASSES.
- busy  output  1  a frame is partially accumulated or a result is pending.

Behaviour:
- Beat accepted iff in_valid && in_ready. in_ready = 1 in ACCUM and 0 in DONE; in_ready = 0 in any cycle with RST high.
- States:
  - ACCUM: collecting beats. Registers: cnt (0..NUM_CLASSES-1), best, second, best_idx.
  - DONE: result presented on the outputs.
- First beat (cnt = 0):
  - best ← in_data, best_idx ← 0, second ← most-negative value (−2^(DATA_W-1)).
- Later beats:
  - If in_data > best (signed, strict): second ← best, best ← in_data, best_idx ← cnt.
  - Else if in_data > second: second ← in_data.
- Tie rule: the lower index wins. A score equal to best updates second only, so margin = 0.
- Frame end: the accepted beat where in_last = 1 or cnt = NUM_CLASSES-1, whichever comes first.
  - frame_err ← 1 if those two conditions do not coincide on that beat, i.e. in_last early or missing.
  - Any beat after an early end belongs to the next frame.
- Latency: on the frame-end beat, outputs are registered (including the final beat's contribution). out_valid = 1 in the next cycle and the FSM moves to DONE.
- DONE:
  - class_idx, max_score, margin and frame_err are stable while out_valid && !out_ready.
  - On out_ready = 1, next cycle: out_valid = 0, state ACCUM, cnt = 0, in_ready = 1.
  - No beat is accepted in the cycle the result handshakes.
- margin:
  - Computed at DATA_W+1 bits as best − second.
  - Saturates to 2^(DATA_W-1)−1 if larger. It is never negative.
  - If an early in_last ends a 1-beat frame, second is still most-negative, so margin saturates (and frame_err = 1).
- busy = (state == DONE) || (cnt != 0).
- Reset (any cycle, including mid-frame or with out_valid pending):
  - Partial frame and pending result are discarded; state = ACCUM, cnt = 0.
  - out_valid = 0, class_idx = 0, max_score = 0, margin = 0, frame_err = 0, busy = 0.
  - in_valid beats during RST are ignored.
- Throughput: one beat per cycle while in ACCUM. Minimum frame period is NUM_CLASSES + 1 cycles with out_ready tied high.

Test Plan:
- Basic frame: scores 5,−3,100,7,0,2,99,−128,1,4 back-to-back, in_last on beat 9, out_ready = 1 → one cycle after beat 9: out_valid = 1, class_idx = 2, max_score = 100, margin = 1, frame_err = 0; in_ready returns to 1 the following cycle.
- Ties and negatives: all ten scores = −50 → class_idx = 0, max_score = −50 (0xFFCE), margin = 0. Scores 3,9,9,0… → class_idx = 1, margin = 0.
- Saturation and back-pressure:
  - Frame 0x7FFF then nine 0x8000 → class_idx = 0, margin = 0x7FFF (saturated).
  - Hold out_ready = 0 for 5 cycles → outputs stable, in_ready = 0, and new in_valid beats are not consumed.
- Framing errors:
  - in_last on beat 3 of scores 1,2,8,4 → result class_idx = 2, margin = 4, frame_err = 1.
  - A following 10-beat frame whose last beat lacks in_last → frame_err = 1; the next correct frame → frame_err = 0.
- Reset mid-frame: assert RST for 1 cycle after 6 beats, then send a full frame with max at index 9 → only one result, class_idx = 9; all outputs 0 and busy = 0 during and right after RST.
- Throttled input: random in_valid gaps (about 50% duty) over 100 frames versus a reference model → every class_idx, max_score and margin matches; no beat lost or duplicated.
